attractor_classifier: RTL and testbench

Parametrised attractor analyser for the gene-network simulator. Given an initial state, it iterates an externally supplied W-bit next-state function, classifies the trajectory as fixed point or cycle, and reports cycle length, transient length and attractor entry state. It supersedes the separate fixed-point and cycle checkers, generalising them from 8 bits to any W. The next-state function is a combinational gene-network evaluator attached through the `fn_in`/`fn_out` port pair.

---
 rtl/attractor_classifier.sv | 181 ++++++++++++++++++
 tb/tb_attractor_classifier.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/attractor_classifier.sv
// Attractor analyser: Brent cycle detection plus mu search over an external
// W-bit next-state function, reporting period, transient and entry state.
module attractor_classifier #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] init_val,
  output logic [W-1:0] fn_in,
  input  logic [W-1:0] fn_out,
  output logic         busy,
  output logic         done,
  output logic         is_fixed,
  output logic [W:0]   cycle_len,
  output logic [W:0]   transient_len,
  output logic [W-1:0] entry_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LAM, S_ADV, S_MU, S_DONE
  } state_t;

  localparam logic [W+1:0] LAM_ONE = 1;
  localparam logic [W:0]   CNT_ONE = 1;

  state_t       state_q, state_d;
  logic [W-1:0] x0_q, x0_d;
  logic [W-1:0] tort_q, tort_d;
  logic [W-1:0] hare_q, hare_d;
  logic [W+1:0] power_q, power_d;
  logic [W+1:0] lam_q, lam_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         phase_q, phase_d;
  logic [W-1:0] fn_in_q, fn_in_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         fixed_q, fixed_d;
  logic [W:0]   clen_q, clen_d;
  logic [W:0]   tlen_q, tlen_d;
  logic [W-1:0] entry_q, entry_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      tort_q  <= '0;
      hare_q  <= '0;
      power_q <= '0;
      lam_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      fn_in_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fixed_q <= 1'b0;
      clen_q  <= '0;
      tlen_q  <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      tort_q  <= tort_d;
      hare_q  <= hare_d;
      power_q <= power_d;
      lam_q   <= lam_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      fn_in_q <= fn_in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fixed_q <= fixed_d;
      clen_q  <= clen_d;
      tlen_q  <= tlen_d;
      entry_q <= entry_d;
    end
  end

  // fn_in_d always holds the value of whichever register the next state
  // advances, so fn_out is valid for it throughout that cycle.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    tort_d  = tort_q;
    hare_d  = hare_q;
    power_d = power_q;
    lam_d   = lam_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    fn_in_d = fn_in_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fixed_d = fixed_q;
    clen_d  = clen_q;
    tlen_d  = tlen_q;
    entry_d = entry_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = init_val;
          fn_in_d = init_val;
          busy_d  = 1'b1;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        hare_d  = fn_out;
        tort_d  = x0_q;
        power_d = LAM_ONE;
        lam_d   = LAM_ONE;
        fn_in_d = fn_out;
        state_d = S_LAM;
      end
      S_LAM: begin
        if (tort_q == hare_q) begin
          tort_d  = x0_q;
          hare_d  = x0_q;
          cnt_d   = '0;
          fn_in_d = x0_q;
          state_d = S_ADV;
        end else begin
          if (power_q == lam_q) begin
            tort_d  = hare_q;
            power_d = power_q << 1;
            lam_d   = LAM_ONE;
          end else begin
            lam_d = lam_q + LAM_ONE;
          end
          hare_d  = fn_out;
          fn_in_d = fn_out;
        end
      end
      S_ADV: begin
        hare_d  = fn_out;
        cnt_d   = cnt_q + CNT_ONE;
        fn_in_d = fn_out;
        if ((cnt_q + CNT_ONE) == lam_q[W:0]) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          fn_in_d = tort_q;
          state_d = S_MU;
        end
      end
      S_MU: begin
        if (!phase_q) begin
          if (tort_q == hare_q) begin
            state_d = S_DONE;
          end else begin
            tort_d  = fn_out;
            fn_in_d = hare_q;
            phase_d = 1'b1;
          end
        end else begin
          hare_d  = fn_out;
          cnt_d   = cnt_q + CNT_ONE;
          fn_in_d = tort_q;
          phase_d = 1'b0;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        clen_d  = lam_q[W:0];
        tlen_d  = cnt_q;
        entry_d = tort_q;
        fixed_d = (lam_q == LAM_ONE);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fn_in         = fn_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign is_fixed      = fixed_q;
  assign cycle_len     = clen_q;
  assign transient_len = tlen_q;
  assign entry_state   = entry_q;

endmodule

// File: tb/tb_attractor_classifier.sv
// Scoreboard bench: W=8 directed runs and a W=4 exhaustive x0 sweep
// against a visited-index reference model.
module tb_attractor_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, busy8, done8, fx8;
  logic [7:0] init8, fn_in8, fn_out8, es8;
  logic [8:0] cl8, tl8;
  logic       start4, busy4, done4, fx4;
  logic [3:0] init4, fn_in4, fn_out4, es4;
  logic [4:0] cl4, tl4;

  int mode8;
  logic [3:0] tab4 [16];

  attractor_classifier #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .init_val(init8),
    .fn_in(fn_in8), .fn_out(fn_out8), .busy(busy8), .done(done8),
    .is_fixed(fx8), .cycle_len(cl8), .transient_len(tl8),
    .entry_state(es8)
  );

  attractor_classifier #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .init_val(init4),
    .fn_in(fn_in4), .fn_out(fn_out4), .busy(busy4), .done(done4),
    .is_fixed(fx4), .cycle_len(cl4), .transient_len(tl4),
    .entry_state(es4)
  );

  always_comb begin
    fn_out8 = fn_in8;
    case (mode8)
      1: fn_out8 = fn_in8 + 8'd1;
      2: fn_out8 = (fn_in8 < 8'd5) ? fn_in8 + 8'd1 : 8'd5;
      3: fn_out8 = (fn_in8 < 8'd5) ? fn_in8 + 8'd1 :
                   (fn_in8 == 8'd5) ? 8'd3 : fn_in8;
      default: fn_out8 = fn_in8;
    endcase
  end

  assign fn_out4 = tab4[fn_in4];

  typedef struct {
    int cl;
    int tl;
    int es;
    int fx;
    int t0;
    int lat;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, int act, int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        total++;
        $display("FAIL unexpected_done8: done=1 required=0");
      end else begin
        e = q8.pop_front();
        check("cycle_len8", int'(cl8), e.cl);
        check("transient_len8", int'(tl8), e.tl);
        check("entry_state8", int'(es8), e.es);
        check("is_fixed8", int'(fx8), e.fx);
        check("busy_at_done8", int'(busy8), 0);
        if (e.lat >= 0) check("latency8", cyc - e.t0, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        total++;
        $display("FAIL unexpected_done4: done=1 required=0");
      end else begin
        e = q4.pop_front();
        check("cycle_len4", int'(cl4), e.cl);
        check("transient_len4", int'(tl4), e.tl);
        check("entry_state4", int'(es4), e.es);
        check("is_fixed4", int'(fx4), e.fx);
        check("busy_at_done4", int'(busy4), 0);
      end
    end
  end

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      $display("FAIL timeout8: done=0 required=1");
    end
  endtask

  task automatic wait_done4();
    int n = 0;
    while (!done4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      $display("FAIL timeout4: done=0 required=1");
    end
  endtask

  task automatic run8(int m, logic [7:0] x, int cl, int tl, int es,
                      int fx, int lat, bit poke);
    exp_t e;
    @(negedge clk);
    mode8 = m;
    init8 = x;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    e.cl = cl; e.tl = tl; e.es = es; e.fx = fx;
    e.t0 = cyc; e.lat = lat;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    if (poke) begin
      @(negedge clk);
      init8 = 8'h7C;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      check("busy_after_poke", int'(busy8), 1);
    end
    wait_done8();
  endtask

  task automatic model4(int x, output exp_t e);
    int first [16];
    int cur;
    int k;
    for (int i = 0; i < 16; i++) first[i] = -1;
    cur = x;
    k = 0;
    while (first[cur] < 0) begin
      first[cur] = k;
      cur = int'(tab4[cur]);
      k++;
    end
    e.tl = first[cur];
    e.cl = k - first[cur];
    e.es = cur;
    e.fx = (e.cl == 1) ? 1 : 0;
    e.t0 = 0;
    e.lat = -1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    start8 = 1'b0; init8 = '0; mode8 = 0;
    start4 = 1'b0; init4 = '0;
    for (int i = 0; i < 16; i++) tab4[i] = 4'(i);
    #12;
    check("rst_busy8", int'(busy8), 0);
    check("rst_done8", int'(done8), 0);
    check("rst_cl8", int'(cl8), 0);
    check("rst_fn_in8", int'(fn_in8), 0);
    check("rst_busy4", int'(busy4), 0);
    check("rst_cl4", int'(cl4), 0);
    @(negedge clk);
    rst = 1'b0;

    run8(0, 8'h00, 1, 0, 8'h00, 1, 5, 1'b0);
    run8(1, 8'h38, 256, 0, 8'h38, 0, -1, 1'b0);
    run8(2, 8'h00, 1, 5, 5, 1, -1, 1'b0);
    run8(3, 8'h00, 3, 3, 3, 0, -1, 1'b1);
    run8(3, 8'h04, 3, 0, 4, 0, -1, 1'b0);

    @(negedge clk);
    mode8 = 1;
    init8 = 8'h10;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_before_rst", int'(busy8), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy8), 0);
    check("rst_mid_done", int'(done8), 0);
    check("rst_mid_cl", int'(cl8), 0);
    check("rst_mid_tl", int'(tl8), 0);
    check("rst_mid_es", int'(es8), 0);
    check("rst_mid_fx", int'(fx8), 0);
    check("rst_mid_fn_in", int'(fn_in8), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run8(1, 8'h63, 256, 0, 8'h63, 0, -1, 1'b0);

    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++)
        tab4[i] = (s == 0) ? 4'(i + 1) : 4'($urandom_range(0, 15));
      init4 = 4'd0;
      start4 = 1'b1;
      model4(0, e);
      q4.push_back(e);
      for (int x = 0; x < 16; x++) begin
        @(posedge clk);
        #1;
        check("b2b_busy4", int'(busy4), 1);
        @(negedge clk);
        start4 = 1'b0;
        wait_done4();
        if (x < 15) begin
          init4 = 4'(x + 1);
          start4 = 1'b1;
          model4(x + 1, e);
          q4.push_back(e);
        end
      end
    end

    repeat (4) @(negedge clk);
    if (q8.size() != 0 || q4.size() != 0) begin
      total++;
      $display("FAIL pending_results: left=%0d required=0",
               q8.size() + q4.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
